hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hz_stage_reg.sv | 22 ++
 rtl/hazard_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and the shadow-stage record for the pipeline hazard controller.
package hazard_pkg;
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;
  localparam logic [4:0] REG_X0  = 5'd0;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } stage_t;

  localparam int STAGE_W = $bits(stage_t);

  // MEM wins over WB: it holds the younger write to the same register.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input stage_t m, input stage_t w);
    if (m.reg_write && m.rd != REG_X0 && m.rd == rs)      return FWD_MEM;
    else if (w.reg_write && w.rd != REG_X0 && w.rd == rs) return FWD_WB;
    else                                                  return FWD_RF;
  endfunction
endpackage

// File: rtl/hz_stage_reg.sv
// One shadow pipeline register: bubble holds, flush clears, otherwise load.
module hz_stage_reg #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bubble,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_q <= '0;
    else if (bubble)  r_q <= r_q;
    else if (flush)   r_q <= '0;
    else              r_q <= d;
  end

  assign q = r_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit: stall/flush arbitration for memory wait, taken branch and
// load-use, plus EX operand forwarding, tracked through shadow E/M/W stages.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_D,
  input  logic [4:0]  rs2_D,
  input  logic        rs1_used_D,
  input  logic        rs2_used_D,
  input  logic [4:0]  rd_D,
  input  logic        reg_write_D,
  input  logic        mem_read_D,
  input  logic        br_taken_E,
  input  logic        mem_req_M,
  input  logic        mem_ack_M,
  output logic        bubbleF,
  output logic        bubbleD,
  output logic        bubbleE,
  output logic        bubbleM,
  output logic        bubbleW,
  output logic        flushD,
  output logic        flushE,
  output logic        flushM,
  output logic        flushW,
  output logic [1:0]  fwd1_sel_E,
  output logic [1:0]  fwd2_sel_E,
  output logic [31:0] stall_cnt
);
  stage_t w_d, w_e, w_m, w_w;
  logic   w_wait, w_branch, w_load_use;
  logic   r_unused_guard;
  logic   w_unused;
  logic [31:0] r_stall_cnt;

  assign w_d = '{rs1: rs1_D, rs2: rs2_D, rd: rd_D, reg_write: reg_write_D, mem_read: mem_read_D};

  assign w_wait   = mem_req_M & ~mem_ack_M;
  assign w_branch = br_taken_E & ~w_wait;
  assign w_load_use = w_e.mem_read && (w_e.rd != REG_X0) && !w_wait && !br_taken_E &&
                      ((rs1_used_D && rs1_D == w_e.rd) || (rs2_used_D && rs2_D == w_e.rd));

  // Reset gates the controls so a stall collapses the instant rst rises.
  always_comb begin
    bubbleF = 1'b0; bubbleD = 1'b0; bubbleE = 1'b0; bubbleM = 1'b0; bubbleW = 1'b0;
    flushD  = 1'b0; flushE  = 1'b0; flushM  = 1'b0; flushW  = 1'b0;
    if (!rst) begin
      if (w_wait) begin
        bubbleF = 1'b1; bubbleD = 1'b1; bubbleE = 1'b1; bubbleM = 1'b1;
        flushW  = 1'b1;
      end else if (w_branch) begin
        flushD = 1'b1; flushE = 1'b1;
      end else if (w_load_use) begin
        bubbleF = 1'b1; bubbleD = 1'b1; flushE = 1'b1;
      end
    end
  end

  assign fwd1_sel_E = fwd_sel(w_e.rs1, w_m, w_w);
  assign fwd2_sel_E = fwd_sel(w_e.rs2, w_m, w_w);

  hz_stage_reg #(.W(STAGE_W)) u_stage_e (
    .clk(clk), .rst(rst), .bubble(bubbleE), .flush(flushE), .d(w_d), .q(w_e)
  );
  hz_stage_reg #(.W(STAGE_W)) u_stage_m (
    .clk(clk), .rst(rst), .bubble(bubbleM), .flush(flushM), .d(w_e), .q(w_m)
  );
  hz_stage_reg #(.W(STAGE_W)) u_stage_w (
    .clk(clk), .rst(rst), .bubble(bubbleW), .flush(flushW), .d(w_m), .q(w_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_stall_cnt <= '0;
    else if (bubbleF) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;

  // WB-stage source fields and load flag have no consumer past writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_unused_guard <= 1'b0;
    else     r_unused_guard <= 1'b0;
  end
  assign w_unused = ^{w_w.rs1, w_w.rs2, w_w.mem_read, r_unused_guard};
endmodule
